serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Multi-cycle controller that reuses one 4-bit ripple adder slice to add two NIBBLES×4-bit operands, one nibble per clock, LSB nibble first.
- Holds the inter-nibble carry in a register and runs a start/busy/done handshake.
- Sits between the lab datapath registers and the shared 4-bit adder: it sequences the adder rather than widening it.

Parameters:
- NIBBLES, 4, operand width in 4-bit nibbles (W = 4*NIBBLES); legal 2..16.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- x  input  W  operand A, sampled on the accepting edge
- y  input  W  operand B, sampled on the accepting edge
- c_in  input  1  carry into nibble 0, sampled on the accepting edge
- busy  output  1  high while in RUN or DONE
- done  output  1  one-cycle completion pulse
- out  output  W  result sum
- c_out  output  1  carry out of the MSB nibble

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high.
- Reset values, applied on any edge with reset=1:
  - state = IDLE; busy = 0, done = 0, out = 0, c_out = 0.
  - Internal operand, counter, carry and working-sum registers are cleared.
  - Reset during RUN or DONE aborts the operation; no done pulse is produced for it.
  - Reset has priority over start.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy = 0.
  - On an edge with start = 1: latch x, y into operand registers; set carry register = c_in; set nibble counter cnt = 0; go to RUN.
- RUN (busy = 1):
  - Each edge computes {carry', s} = xa[4cnt+3:4cnt] + ya[4cnt+3:4cnt] + carry using the ripple-adder equations: per bit, g = a&b, p = a^b, sum = p^c, cout = (p&c)|g.
  - s is written into working-sum nibble cnt; the carry register takes carry'.
  - If cnt == NIBBLES-1, go to DONE; otherwise cnt increments.
- DONE:
  - done = 1 for exactly this one cycle.
  - out and c_out are loaded from the working sum and final carry on the edge entering DONE.
  - Next edge returns to IDLE.
- Latency: start is sampled at edge E0; done is high in the cycle after edge E0+NIBBLES.
  - Back-to-back operations take NIBBLES+2 cycles each.
- Output stability: out and c_out hold the last completed result until the next DONE entry.
  - They are not disturbed by RUN, by start, or by changes on x/y.
- Request rules:
  - start is ignored in RUN and DONE; it is neither queued nor an error.
  - An ignored start does not alter any register.
- Arithmetic:
  - Unsigned modulo 2^W; the carry out of the MSB nibble goes only to c_out.
  - No intermediate value is wider than 5 bits.
- x, y and c_in may change freely after the accepting edge; only the latched copies are used.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds port sub (input, 1), sampled with start.
  - If sub = 1: ya latches ~y, the carry register initialises to 1 and c_in is ignored, so out = x − y mod 2^W.
  - In subtract mode, c_out = 1 means no borrow (x ≥ y).
  - If sub = 0: behaviour is identical to the plain add.
- When not defined: there is no sub port and the block is add-only.

Test Plan (NIBBLES=4):
- Basic add: x=0x1234, y=0x4321, c_in=0, start at E0 → done high only in the cycle after E4; out=0x5555, c_out=0; busy high E0..E5, low after.
- Carry across nibbles: x=0xFFFF, y=0x0001, c_in=0 → out=0x0000, c_out=1. Then x=0xFFFF, y=0x0000, c_in=1 → out=0x0000, c_out=1.
- Start while busy: start at E0 (0x0F0F+0x00F1); start again at E2 with x=0xAAAA → out=0x1000, c_out=0; only one done pulse. Between ops, out holds the previous result.
- Reset mid-operation: start 0x8000+0x8000; reset=1 at E2 → busy=0, done=0, out=0, c_out=0 after E2; no done pulse; next start works normally.
- Back-to-back: start held high continuously with x=0x0001, y=0x0001 → done pulses every 6 cycles; out=0x0002 each time.
- SERIAL_ADDER_SUB_EN: x=0x0005, y=0x0007, sub=1 → out=0xFFFE, c_out=0. Then x=0x0007, y=0x0005, sub=1 → out=0x0002, c_out=1.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module   : serial_adder_ctrl
// Adds two NIBBLES*4-bit operands one nibble per clock through a single
// 4-bit ripple slice, with a start/busy/done handshake.
// Optional : `define SERIAL_ADDER_SUB_EN adds a 'sub' port (x - y mode).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] x,
  input  logic [4*NIBBLES-1:0] y,
  input  logic                 c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] out,
  output logic                 c_out
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    xa_q, xa_d;
  logic [W-1:0]    ya_q, ya_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [W-1:0]    out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;

  // Shared 4-bit ripple slice on the current nibble.
  logic [3:0]      nib_a, nib_b, nib_g, nib_p, nib_s;
  logic            nib_c;

  always_comb begin
    nib_a = xa_q[{cnt_q, 2'b00} +: 4];
    nib_b = ya_q[{cnt_q, 2'b00} +: 4];
    nib_g = nib_a & nib_b;
    nib_p = nib_a ^ nib_b;
    nib_s = 4'd0;
    nib_c = carry_q;
    for (int i = 0; i < 4; i++) begin
      nib_s[i] = nib_p[i] ^ nib_c;
      nib_c    = (nib_p[i] & nib_c) | nib_g[i];
    end
  end

  always_comb begin
    state_d = state_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    sum_d   = sum_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          xa_d    = x;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SERIAL_ADDER_SUB_EN
          // Two's-complement subtract: invert y and force the initial carry.
          ya_d    = sub ? ~y : y;
          carry_d = sub ? 1'b1 : c_in;
`else
          ya_d    = y;
          carry_d = c_in;
`endif
        end
      end
      RUN: begin
        sum_d[{cnt_q, 2'b00} +: 4] = nib_s;
        carry_d = nib_c;
        if (cnt_q == CW'(NIBBLES - 1)) begin
          out_d   = sum_d;
          cout_d  = nib_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      xa_q    <= '0;
      ya_q    <= '0;
      sum_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      sum_q   <= sum_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy  = (state_q == RUN) || (state_q == DONE);
  assign done  = (state_q == DONE);
  assign out   = out_q;
  assign c_out = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// Module   : tb_serial_adder_ctrl
// Directed bench for serial_adder_ctrl against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         c_in;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         c_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
    .y     (y),
    .c_in  (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .out   (out),
    .c_out (c_out)
  );

  // Transaction model: an accepted request yields (x + y + c_in) after a
  // fixed number of cycles; m_left counts cycles remaining until idle.
  int         m_left = 0;
  logic [W:0] m_res  = '0;
  logic [W-1:0] m_out = '0;
  logic       m_cout = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_out  = '0;
      m_cout = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) m_res = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else     m_res = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c_in};
`else
        m_res = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c_in};
`endif
        m_left = NIBBLES + 1;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        m_out  = m_res[W-1:0];
        m_cout = m_res[W];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and check every output against the model.
  task automatic tick();
    @(negedge clk);
    chk("busy",  64'(busy),  64'(m_left > 0));
    chk("done",  64'(done),  64'(m_left == 1));
    chk("out",   64'(out),   64'(m_out));
    chk("c_out", 64'(c_out), 64'(m_cout));
  endtask

  // Issue one request, scramble inputs afterwards, and wait for done.
  task automatic do_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                       input logic cv, input logic sv, output int lat);
    bit found;
    start = 1'b1; x = xv; y = yv; c_in = cv; sub = sv;
    tick();
    start = 1'b0; x = W'($urandom); y = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (done) begin
        found = 1'b1;
        lat   = i;
      end
    end
    if (!found) chk("done_timeout", 64'(0), 64'(1));
    tick();
  endtask

  initial begin
    int lat;
    int pulses;
    int last_pulse;

    reset = 1'b1; start = 1'b0; x = '0; y = '0; c_in = 1'b0; sub = 1'b0;
    tick();
    tick();
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_out",  64'(out),  64'(0));
    reset = 1'b0;
    tick();

    // Basic add
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    chk("basic_lat",  64'(lat),   64'(NIBBLES));
    chk("basic_out",  64'(out),   64'h5555);
    chk("basic_cout", 64'(c_out), 64'(0));
    chk("basic_idle", 64'(busy),  64'(0));

    // Carry across all nibbles
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    chk("carry1_out",  64'(out),   64'h0000);
    chk("carry1_cout", 64'(c_out), 64'(1));
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat);
    chk("carry2_out",  64'(out),   64'h0000);
    chk("carry2_cout", 64'(c_out), 64'(1));

    // Start while busy is ignored
    start = 1'b1; x = 16'h0F0F; y = 16'h00F1; c_in = 1'b0; sub = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("busy_hold_out", 64'(out), 64'h0000);
    start = 1'b1; x = 16'hAAAA;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("busy_pulses", 64'(pulses), 64'(1));
    chk("busy_out",    64'(out),    64'h1000);
    chk("busy_cout",   64'(c_out),  64'(0));

    // Reset mid-operation
    start = 1'b1; x = 16'h8000; y = 16'h8000; c_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", 64'(busy),  64'(0));
    chk("rst_done", 64'(done),  64'(0));
    chk("rst_out",  64'(out),   64'(0));
    chk("rst_cout", 64'(c_out), 64'(0));
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("rst_pulses", 64'(pulses), 64'(0));
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    chk("rst_next_out", 64'(out), 64'h5555);

    // Back-to-back with start held high
    start = 1'b1; x = 16'h0001; y = 16'h0001; c_in = 1'b0; sub = 1'b0;
    pulses = 0;
    last_pulse = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done) begin
        if (last_pulse >= 0) chk("b2b_period", 64'(i - last_pulse), 64'(NIBBLES + 2));
        last_pulse = i;
        pulses++;
      end
    end
    start = 1'b0;
    chk("b2b_pulses", 64'(pulses), 64'(5));
    chk("b2b_out",    64'(out),    64'h0002);
    for (int i = 0; i < 10; i++) tick();
    chk("b2b_idle", 64'(busy), 64'(0));

`ifdef SERIAL_ADDER_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
    chk("sub1_out",  64'(out),   64'hFFFE);
    chk("sub1_cout", 64'(c_out), 64'(0));
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, lat);
    chk("sub2_out",  64'(out),   64'h0002);
    chk("sub2_cout", 64'(c_out), 64'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
